cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- 4-way set-associative, write-allocate L1 cache controller between a CPU port and a word-wide memory refill port.
- Lines are 4 x 32-bit words (128 bits); replacement is true LRU.
- A miss fetches the whole line from memory in 4 acknowledged beats through an MSHR-style line buffer, installs it, then answers the CPU.
- Write hits update the cache only; no write-back path exists (dirty data is dropped on eviction).

Parameters:
ADR_WIDTH, 32, address width
DATA_WIDTH, 32, CPU/memory word width
WORD_OFFSET, 2, word-select bits (4 words per line)
DATAMEM_WIDTH, 128, line width (DATA_WIDTH << WORD_OFFSET)
INDEX_WIDTH, 6, set-index bits (64 sets)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_cpu2cc  in  1  CPU request, level; held until CPU chooses to drop it
adr_cpu2cc  in  ADR_WIDTH  byte address
dat_cpu2cc  in  DATA_WIDTH  write data
rdwr_cpu2cc  in  1  0=read, 1=write
ack_cc2cpu  out  1  one-cycle completion pulse
dat_cc2cpu  out  DATA_WIDTH  read data, valid with ack
req_cc2mem  out  1  line refill request
adr_cc2mem  out  ADR_WIDTH  line-aligned refill address (low 4 bits zero)
ack_mem2cc  in  1  memory beat valid
dat_mem2cc  in  DATA_WIDTH  memory beat data
dat_mem2mshr  out  DATA_WIDTH  current beat forwarded into line buffer
word_mem2mshr  out  WORD_OFFSET  beat/word index being filled
dat_cc2mshr  out  DATAMEM_WIDTH  line buffer contents

Behaviour:
- Address split:
  - byte [1:0], ignored
  - word [3:2]
  - index [9:4]
  - tag [31:10]
- Per set and way: valid bit, tag, 128-bit data, 2-bit LRU age (0 = MRU, 3 = LRU).
- Reset (async):
  - valid bits cleared; LRU ages set to way number
  - FSM to IDLE; word counter 0; line buffer 0
  - all outputs 0
  - Data/tag arrays need not be reset.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND, RELEASE.
  - IDLE: on req_cpu2cc=1, latch address, write data and rdwr; go to LOOKUP.
  - LOOKUP: compare tag against all 4 ways.
    - Hit: go to RESPOND; read returns the selected word; write updates that word in the hit way.
    - Miss: choose victim (lowest-numbered invalid way, else age==3 way); assert req_cc2mem with adr_cc2mem = {tag,index,4'b0}; go to REFILL.
  - REFILL: each cycle with ack_mem2cc=1:
    - store dat_mem2cc into line buffer at word counter
    - dat_mem2mshr = dat_mem2cc; word_mem2mshr = counter
    - increment counter
    - Words arrive in order 0..3.
    - After the 4th beat: drop req_cc2mem the next cycle; write buffer into victim way with valid=1 and new tag. For a write miss, merge CPU data into the addressed word before install. Reset counter; go to RESPOND.
    - Cycles without ack wait indefinitely.
  - RESPOND: ack_cc2cpu=1 for exactly one cycle; dat_cc2cpu = addressed word (read) or 0 (write). Go to RELEASE.
  - RELEASE: wait for req_cpu2cc=0, then go to IDLE. A still-high request is never re-served.
- Latency from request sampled in IDLE:
  - hit: ack 2 cycles later
  - miss: ack 1 cycle after the 4th memory beat is sampled
- ack_mem2cc outside REFILL is ignored.
- LRU update on every hit or fill of way w in the set:
  - ways with age < age(w) increment
  - age(w) = 0
  - ages always remain a permutation of 0..3
- Reset mid-operation aborts everything: req_cc2mem and ack_cc2cpu go low immediately; a partial line is discarded.
- dat_cc2mshr continuously reflects the line buffer.

Test Plan:
- Reset 42 cycles, idle 512 cycles. Read 0xFF07BD08 -> req_cc2mem=1, adr_cc2mem=0xFF07BD00. Four beats of 0xFFFFFFFF -> ack_cc2cpu pulse, dat_cc2cpu=0xFFFFFFFF, line installed in way 0.
- Read misses 0xA5552D0C, 0xD500AD00, 0xFFFFFD08 (same set, index 0x10) -> installed in ways 1, 2, 3; each needs exactly 4 beats.
- Read hit 0xFF07BD00 -> no req_cc2mem; ack 2 cycles after request, data 0xFFFFFFFF; single ack despite req held 3 cycles.
- Write hit 0xFFFFFD08 data 0x55455552, then write hit 0xA5552D08 data 0xAA8AAAA4. Then read miss 0xAFD52D08 -> victim is way 2 (tag D500A, LRU); 0xD500AD00 subsequently misses.
- Read 0xA5552D08 -> hit, dat_cc2cpu=0xAA8AAAA4.
- Write hits 0xA5552D00, D04, D0C -> ack each, no memory request; read back returns the written values.

Source files
------------

// File: rtl/cache_controller.sv
// 4-way set-associative write-allocate L1 cache controller with true LRU
// replacement and a 4-beat line refill through an MSHR line buffer.
module cache_controller #(
   parameter int ADR_WIDTH     = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int WORD_OFFSET   = 2,
   parameter int DATAMEM_WIDTH = DATA_WIDTH << WORD_OFFSET,
   parameter int INDEX_WIDTH   = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_cpu2cc,
   input  logic [ADR_WIDTH-1:0]     adr_cpu2cc,
   input  logic [DATA_WIDTH-1:0]    dat_cpu2cc,
   input  logic                     rdwr_cpu2cc,
   output logic                     ack_cc2cpu,
   output logic [DATA_WIDTH-1:0]    dat_cc2cpu,
   output logic                     req_cc2mem,
   output logic [ADR_WIDTH-1:0]     adr_cc2mem,
   input  logic                     ack_mem2cc,
   input  logic [DATA_WIDTH-1:0]    dat_mem2cc,
   output logic [DATA_WIDTH-1:0]    dat_mem2mshr,
   output logic [WORD_OFFSET-1:0]   word_mem2mshr,
   output logic [DATAMEM_WIDTH-1:0] dat_cc2mshr
);

   localparam int WORDS     = 1 << WORD_OFFSET;
   localparam int SETS      = 1 << INDEX_WIDTH;
   localparam int WAYS      = 4;
   localparam int LSB       = WORD_OFFSET + 2;
   localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - LSB;

   typedef logic [WORDS-1:0][DATA_WIDTH-1:0] line_t;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, REFILL, RESPOND, RELEASE
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [ADR_WIDTH-1:0]   adr_q;
   logic [DATA_WIDTH-1:0]  wdat_q;
   logic                   wr_q;
   logic [WORD_OFFSET-1:0] cnt;
   line_t                  line_buf;
   logic [1:0]             victim_q;
   logic [DATA_WIDTH-1:0]  resp_q;
   logic                   req_q;
   logic [ADR_WIDTH-1:0]   madr_q;

   logic [WAYS-1:0]        valid    [SETS];
   logic [1:0]             age      [SETS][WAYS];
   logic [TAG_WIDTH-1:0]   tag_mem  [SETS][WAYS];
   line_t                  data_mem [SETS][WAYS];

   logic [INDEX_WIDTH-1:0] idx;
   logic [TAG_WIDTH-1:0]   tag;
   logic [WORD_OFFSET-1:0] word;
   logic                   hit;
   logic [1:0]             hit_way;
   logic [1:0]             victim;
   logic                   last_beat;
   line_t                  fill_line;
   logic                   touch;
   logic [1:0]             touch_way;
   logic                   unused_ok;

   assign idx  = adr_q[LSB +: INDEX_WIDTH];
   assign tag  = adr_q[ADR_WIDTH-1 -: TAG_WIDTH];
   assign word = adr_q[2 +: WORD_OFFSET];

   assign unused_ok = &{1'b0, adr_q[1:0]};

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[idx][w] && tag_mem[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = 2'(w);
         end
      end
   end

   // Lowest invalid way wins; otherwise the way whose age is 3.
   always_comb begin
      victim = '0;
      for (int w = 0; w < WAYS; w++)
         if (age[idx][w] == 2'd3) victim = 2'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid[idx][w]) victim = 2'(w);
   end

   assign last_beat = (state == REFILL) && ack_mem2cc && (cnt == '1);

   always_comb begin
      fill_line      = line_buf;
      fill_line[cnt] = dat_mem2cc;
      if (wr_q) fill_line[word] = wdat_q;
   end

   assign touch     = (state == LOOKUP && hit) || last_beat;
   assign touch_way = last_beat ? victim_q : hit_way;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      ack_cc2cpu = 1'b0;
      dat_cc2cpu = '0;
      unique case (state)
         IDLE:    if (req_cpu2cc) state_nx = LOOKUP;
         LOOKUP:  state_nx = hit ? RESPOND : REFILL;
         REFILL:  if (last_beat) state_nx = RESPOND;
         RESPOND: begin
            ack_cc2cpu = 1'b1;
            dat_cc2cpu = resp_q;
            state_nx   = RELEASE;
         end
         RELEASE: if (!req_cpu2cc) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign req_cc2mem    = req_q;
   assign adr_cc2mem    = madr_q;
   assign dat_cc2mshr   = line_buf;
   assign word_mem2mshr = cnt;
   assign dat_mem2mshr  = (state == REFILL && ack_mem2cc) ? dat_mem2cc : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_q    <= '0;
         wdat_q   <= '0;
         wr_q     <= 1'b0;
         cnt      <= '0;
         line_buf <= '0;
         victim_q <= '0;
         resp_q   <= '0;
         req_q    <= 1'b0;
         madr_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid[s][w] <= 1'b0;
               age[s][w]   <= 2'(w);
            end
         end
      end else begin
         if (state == IDLE && req_cpu2cc) begin
            adr_q  <= adr_cpu2cc;
            wdat_q <= dat_cpu2cc;
            wr_q   <= rdwr_cpu2cc;
         end
         if (state == LOOKUP) begin
            if (hit) begin
               resp_q <= wr_q ? '0 : data_mem[idx][hit_way][word];
            end else begin
               victim_q <= victim;
               req_q    <= 1'b1;
               madr_q   <= {adr_q[ADR_WIDTH-1:LSB], {LSB{1'b0}}};
            end
         end
         if (state == REFILL && ack_mem2cc) begin
            line_buf[cnt] <= dat_mem2cc;
            cnt           <= cnt + WORD_OFFSET'(1);
         end
         if (last_beat) begin
            req_q                <= 1'b0;
            valid[idx][victim_q] <= 1'b1;
            resp_q               <= wr_q ? '0 : fill_line[word];
         end
         // Ages stay a permutation: only younger ways than the touched one age.
         if (touch) begin
            for (int w = 0; w < WAYS; w++)
               if (age[idx][w] < age[idx][touch_way])
                  age[idx][w] <= age[idx][w] + 2'd1;
            age[idx][touch_way] <= 2'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == LOOKUP && hit && wr_q)
         data_mem[idx][hit_way][word] <= wdat_q;
      if (last_beat) begin
         data_mem[idx][victim_q] <= fill_line;
         tag_mem[idx][victim_q]  <= tag;
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed + randomized bench for cache_controller against a recency-list
// cache model and a deterministic backing memory.
module tb_cache_controller;

   logic         clk;
   logic         rst;
   logic         req_cpu2cc;
   logic [31:0]  adr_cpu2cc;
   logic [31:0]  dat_cpu2cc;
   logic         rdwr_cpu2cc;
   logic         ack_cc2cpu;
   logic [31:0]  dat_cc2cpu;
   logic         req_cc2mem;
   logic [31:0]  adr_cc2mem;
   logic         ack_mem2cc;
   logic [31:0]  dat_mem2cc;
   logic [31:0]  dat_mem2mshr;
   logic [1:0]   word_mem2mshr;
   logic [127:0] dat_cc2mshr;

   cache_controller dut (
      .clk           (clk),
      .rst           (rst),
      .req_cpu2cc    (req_cpu2cc),
      .adr_cpu2cc    (adr_cpu2cc),
      .dat_cpu2cc    (dat_cpu2cc),
      .rdwr_cpu2cc   (rdwr_cpu2cc),
      .ack_cc2cpu    (ack_cc2cpu),
      .dat_cc2cpu    (dat_cc2cpu),
      .req_cc2mem    (req_cc2mem),
      .adr_cc2mem    (adr_cc2mem),
      .ack_mem2cc    (ack_mem2cc),
      .dat_mem2cc    (dat_mem2cc),
      .dat_mem2mshr  (dat_mem2mshr),
      .word_mem2mshr (word_mem2mshr),
      .dat_cc2mshr   (dat_cc2mshr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: per set, valid/tag/words plus a recency list (MRU first).
   logic        mvalid [64][4];
   logic [21:0] mtag   [64][4];
   logic [31:0] mdata  [64][4][4];
   int          mord   [64][4];
   bit          ones_mode;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (ones_mode) return 32'hFFFF_FFFF;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 4; w++) begin
            mvalid[s][w] = 1'b0;
            mord[s][w]   = w;
         end
   endtask

   task automatic touch(input int s, input int w);
      int p;
      p = 0;
      for (int i = 0; i < 4; i++) if (mord[s][i] == w) p = i;
      for (int i = p; i > 0; i--) mord[s][i] = mord[s][i-1];
      mord[s][0] = w;
   endtask

   task automatic access(input logic [31:0] a, input logic [31:0] d,
                         input bit wr, input int hold);
      int          s;
      int          wd;
      int          way;
      int          beats;
      int          lastc;
      int          ackc;
      bit          hit;
      bit          req_seen;
      bit          ack_seen;
      logic [21:0] t;
      logic [31:0] line;
      logic [31:0] got;
      logic [31:0] exp_d;
      logic [127:0] mshr;
      logic [127:0] exp_line;
      s    = int'(a[9:4]);
      t    = a[31:10];
      wd   = int'(a[3:2]);
      line = {a[31:4], 4'h0};
      hit  = 1'b0;
      way  = 0;
      for (int w = 0; w < 4; w++)
         if (!hit && mvalid[s][w] && mtag[s][w] == t) begin
            hit = 1'b1;
            way = w;
         end
      if (!hit) begin
         way = mord[s][3];
         for (int w = 3; w >= 0; w--) if (!mvalid[s][w]) way = w;
      end
      req_cpu2cc  = 1'b1;
      adr_cpu2cc  = a;
      dat_cpu2cc  = d;
      rdwr_cpu2cc = wr;
      beats = 0; lastc = -1; ackc = -1;
      req_seen = 1'b0; ack_seen = 1'b0; got = '0; mshr = '0;
      for (int c = 1; c <= 300 && !ack_seen; c++) begin
         @(posedge clk); #1;
         ack_mem2cc = 1'b0;
         if (ack_cc2cpu) begin
            ack_seen = 1'b1;
            ackc     = c;
            got      = dat_cc2cpu;
            mshr     = dat_cc2mshr;
            chk("req_drop", 128'(req_cc2mem), 128'(0));
         end else if (req_cc2mem) begin
            if (!req_seen) chk("refill_adr", 128'(adr_cc2mem), 128'(line));
            req_seen = 1'b1;
            if (beats < 4 && $urandom_range(0, 2) != 0) begin
               ack_mem2cc = 1'b1;
               dat_mem2cc = mem_word(line + 32'(beats * 4));
               #1;
               chk("beat_word", 128'(word_mem2mshr), 128'(beats));
               chk("beat_data", 128'(dat_mem2mshr), 128'(dat_mem2cc));
               beats++;
               if (beats == 4) lastc = c;
            end else begin
               dat_mem2cc = $urandom;
            end
         end else begin
            ack_mem2cc = 1'($urandom_range(0, 1));
            dat_mem2cc = $urandom;
         end
      end
      ack_mem2cc = 1'b0;
      chk("ack_seen", 128'(ack_seen), 128'(1));
      if (hit) begin
         chk("hit_noreq", 128'(req_seen), 128'(0));
         chk("hit_lat", 128'(ackc), 128'(2));
         exp_d = wr ? 32'h0 : mdata[s][way][wd];
         if (wr) mdata[s][way][wd] = d;
      end else begin
         chk("miss_req", 128'(req_seen), 128'(1));
         chk("miss_beats", 128'(beats), 128'(4));
         chk("miss_lat", 128'(ackc), 128'(lastc + 1));
         for (int i = 0; i < 4; i++) begin
            mdata[s][way][i]     = mem_word(line + 32'(i * 4));
            exp_line[i*32 +: 32] = mdata[s][way][i];
         end
         chk("mshr_line", mshr, exp_line);
         if (wr) mdata[s][way][wd] = d;
         exp_d        = wr ? 32'h0 : mdata[s][way][wd];
         mvalid[s][way] = 1'b1;
         mtag[s][way]   = t;
      end
      chk("rdata", 128'(got), 128'(exp_d));
      touch(s, way);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("single_ack", 128'(ack_cc2cpu), 128'(0));
      end
      req_cpu2cc = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("quiet", 128'({ack_cc2cpu, req_cc2mem}), 128'(0));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk(tag, {ack_cc2cpu, req_cc2mem, word_mem2mshr, dat_cc2cpu,
                adr_cc2mem, dat_mem2mshr}, 128'(0));
      chk({tag, "_mshr"}, dat_cc2mshr, 128'(0));
   endtask

   logic [21:0] rtags [6];
   logic [5:0]  rsets [3];

   initial begin
      rst = 1'b1; req_cpu2cc = 1'b0; adr_cpu2cc = '0; dat_cpu2cc = '0;
      rdwr_cpu2cc = 1'b0; ack_mem2cc = 1'b0; dat_mem2cc = '0;
      ones_mode = 1'b1;
      model_reset();
      repeat (42) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;
      repeat (512) @(posedge clk);
      #1;
      chk_outputs_zero("idle");

      access(32'hFF07_BD08, 32'h0, 1'b0, 0);
      access(32'hA555_2D0C, 32'h0, 1'b0, 0);
      access(32'hD500_AD00, 32'h0, 1'b0, 0);
      access(32'hFFFF_FD08, 32'h0, 1'b0, 0);
      access(32'hFF07_BD00, 32'h0, 1'b0, 2);
      access(32'hFFFF_FD08, 32'h5545_5552, 1'b1, 0);
      access(32'hA555_2D08, 32'hAA8A_AAA4, 1'b1, 0);
      access(32'hAFD5_2D08, 32'h0, 1'b0, 0);
      access(32'hD500_AD00, 32'h0, 1'b0, 0);
      access(32'hA555_2D08, 32'h0, 1'b0, 0);
      access(32'hA555_2D00, 32'h1111_0000, 1'b1, 0);
      access(32'hA555_2D04, 32'h2222_0004, 1'b1, 0);
      access(32'hA555_2D0C, 32'h3333_000C, 1'b1, 0);
      access(32'hA555_2D00, 32'h0, 1'b0, 0);
      access(32'hA555_2D04, 32'h0, 1'b0, 0);
      access(32'hA555_2D0C, 32'h0, 1'b0, 1);

      // Abort a refill half way through with an asynchronous reset.
      req_cpu2cc = 1'b1; adr_cpu2cc = 32'h1234_5D04; rdwr_cpu2cc = 1'b0;
      for (int c = 0; c < 20 && !req_cc2mem; c++) begin
         @(posedge clk); #1;
      end
      chk("abort_req_up", 128'(req_cc2mem), 128'(1));
      ack_mem2cc = 1'b1; dat_mem2cc = 32'hDEAD_BEEF;
      repeat (2) begin @(posedge clk); #1; end
      ack_mem2cc = 1'b0;
      chk("abort_partial", 128'(dat_cc2mshr[63:0]), 128'(64'hDEAD_BEEF_DEAD_BEEF));
      rst = 1'b1;
      #1;
      chk_outputs_zero("abort_reset");
      req_cpu2cc = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      access(32'hFF07_BD08, 32'h0, 1'b0, 0);
      access(32'h1234_5D04, 32'h0, 1'b0, 0);

      ones_mode = 1'b0;
      rtags = '{22'h3FC1EF, 22'h29554B, 22'h35402B, 22'h3FFFFF, 22'h000123, 22'h2BF54B};
      rsets = '{6'h10, 6'h11, 6'h2A};
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = {rtags[$urandom_range(0, 5)], rsets[$urandom_range(0, 2)],
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         access(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
